// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-addressed data memory: byte-addressed CPU
// requests become word accesses, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_d,
  output logic              mem_we,
  input  logic [31:0]       mem_spo
);

  localparam int unsigned BA_W = ADDR_W + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  logic [1:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [BA_W-1:0] addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_d_q, mem_d_d;
  logic            mem_we_q, mem_we_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [31:0]     load_c;
  logic [31:0]     merge_c;

  // Address bits above the word index alias and are deliberately dropped.
  logic            unused_addr;
  assign unused_addr = ^addr[31:BA_W];

  function automatic logic misaligned_f(input logic [2:0] o, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (o)
      OP_LW, OP_SW:         m = (a != 2'd0);
      OP_LH, OP_LHU, OP_SH: m = a[0];
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

  // Lane selection / extension for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_c  = mem_spo[7:0];
    half_c  = addr_q[1] ? mem_spo[31:16] : mem_spo[15:0];
    load_c  = mem_spo;
    merge_c = mem_spo;
    case (addr_q[1:0])
      2'd0:    byte_c = mem_spo[7:0];
      2'd1:    byte_c = mem_spo[15:8];
      2'd2:    byte_c = mem_spo[23:16];
      default: byte_c = mem_spo[31:24];
    endcase
    case (op_q)
      OP_LH:   load_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  load_c = {16'h0000, half_c};
      OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  load_c = {24'h000000, byte_c};
      default: load_c = mem_spo;
    endcase
    if (op_q == OP_SH) begin
      if (addr_q[1]) merge_c[31:16] = wdata_q;
      else           merge_c[15:0]  = wdata_q;
    end else begin
      case (addr_q[1:0])
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and registered-output logic; memory controls are set up one
  // edge early so they are valid throughout the ACCESS/WRITE cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_d_d  = mem_d_q;
    mem_we_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = addr[BA_W-1:0];
          wdata_d = wdata[15:0];
          if (misaligned_f(op, addr[1:0])) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
            if (op == OP_SW) begin
              mem_we_d = 1'b1;
              mem_d_d  = wdata;
            end
          end
        end
      end
      S_ACCESS: begin
        case (op_q)
          OP_SW: begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
          OP_SH, OP_SB: begin
            mem_d_d  = merge_c;
            mem_we_d = 1'b1;
            state_d  = S_WRITE;
          end
          default: begin
            rdata_d = load_c;
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        endcase
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      addr_q   <= BA_W'(0);
      wdata_q  <= 16'h0000;
      rdata_q  <= 32'h0;
      mem_d_q  <= 32'h0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_d_q  <= mem_d_d;
      mem_we_q <= mem_we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign rdata  = rdata_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign mem_a  = addr_q[BA_W-1:2];
  assign mem_d  = mem_d_q;
  assign mem_we = mem_we_q;

endmodule
